// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: register indexing and the
// control-field encodings carried down the pipeline.
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } regDst_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_FUNCT = 4'd15
  } aluOp_e;

  // $zero is never a real producer, so it can never create a dependency.
  function automatic logic regMatch(input logic [REG_W-1:0] producer,
                                    input logic [REG_W-1:0] consumer);
    return (producer != ZERO_REG) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces one stall cycle, unless that instruction is flushed.
module hazard_detect_unit
  import mips_pkg::*;
(
  input  logic             reset,
  input  logic             flush,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRt,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  output logic             hazard,
  output logic             stall
);

  always_comb begin
    hazard = exMemRead & (regMatch(exRt, idRs) | (idUsesRt & regMatch(exRt, idRt)));
    stall  = hazard & ~flush & ~reset;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Loads the decoded instruction every cycle, or a
// bubble on flush / load-use hazard, and counts load-use stall cycles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Flush,
  input  logic [4:0]            ID_Rs,
  input  logic [4:0]            ID_Rt,
  input  logic [4:0]            ID_Rd,
  input  logic                  ID_UsesRt,
  input  logic [DATA_WIDTH-1:0] ID_ReadData1,
  input  logic [DATA_WIDTH-1:0] ID_ReadData2,
  input  logic [DATA_WIDTH-1:0] ID_Imm,
  input  logic [DATA_WIDTH-1:0] ID_PC4,
  input  logic [4:0]            ID_Shamt,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_ALUSrc,
  input  logic [1:0]            ID_RegDst,
  input  logic [3:0]            ID_ALUOp,
  output logic [4:0]            EX_Rs,
  output logic [4:0]            EX_Rt,
  output logic [4:0]            EX_Rd,
  output logic [DATA_WIDTH-1:0] EX_ReadData1,
  output logic [DATA_WIDTH-1:0] EX_ReadData2,
  output logic [DATA_WIDTH-1:0] EX_Imm,
  output logic [DATA_WIDTH-1:0] EX_PC4,
  output logic [4:0]            EX_Shamt,
  output logic                  EX_RegWrite,
  output logic                  EX_MemRead,
  output logic                  EX_MemWrite,
  output logic                  EX_MemtoReg,
  output logic                  EX_ALUSrc,
  output logic [1:0]            EX_RegDst,
  output logic [3:0]            EX_ALUOp,
  output logic                  EX_Valid,
  output logic                  Stall,
  output logic [CNT_WIDTH-1:0]  StallCount
);

  logic hazard;
  logic bubble;

  hazard_detect_unit uHazard (
    .reset     (reset),
    .flush     (Flush),
    .exMemRead (EX_MemRead),
    .exRt      (EX_Rt),
    .idRs      (ID_Rs),
    .idRt      (ID_Rt),
    .idUsesRt  (ID_UsesRt),
    .hazard    (hazard),
    .stall     (Stall)
  );

  assign bubble = Flush | hazard;

  // ID -> EX boundary: data always follows ID; control and specifiers are
  // zeroed on a bubble so nothing downstream, including forwarding, reacts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_ReadData1 <= '0;
      EX_ReadData2 <= '0;
      EX_Imm       <= '0;
      EX_PC4       <= '0;
      EX_Shamt     <= '0;
      EX_Rs        <= ZERO_REG;
      EX_Rt        <= ZERO_REG;
      EX_Rd        <= ZERO_REG;
      EX_RegWrite  <= 1'b0;
      EX_MemRead   <= 1'b0;
      EX_MemWrite  <= 1'b0;
      EX_MemtoReg  <= 1'b0;
      EX_ALUSrc    <= 1'b0;
      EX_RegDst    <= REGDST_RT;
      EX_ALUOp     <= ALU_ADD;
      EX_Valid     <= 1'b0;
    end else begin
      EX_ReadData1 <= ID_ReadData1;
      EX_ReadData2 <= ID_ReadData2;
      EX_Imm       <= ID_Imm;
      EX_PC4       <= ID_PC4;
      EX_Shamt     <= ID_Shamt;
      if (bubble) begin
        EX_Rs       <= ZERO_REG;
        EX_Rt       <= ZERO_REG;
        EX_Rd       <= ZERO_REG;
        EX_RegWrite <= 1'b0;
        EX_MemRead  <= 1'b0;
        EX_MemWrite <= 1'b0;
        EX_MemtoReg <= 1'b0;
        EX_ALUSrc   <= 1'b0;
        EX_RegDst   <= REGDST_RT;
        EX_ALUOp    <= ALU_ADD;
        EX_Valid    <= 1'b0;
      end else begin
        EX_Rs       <= ID_Rs;
        EX_Rt       <= ID_Rt;
        EX_Rd       <= ID_Rd;
        EX_RegWrite <= ID_RegWrite;
        EX_MemRead  <= ID_MemRead;
        EX_MemWrite <= ID_MemWrite;
        EX_MemtoReg <= ID_MemtoReg;
        EX_ALUSrc   <= ID_ALUSrc;
        EX_RegDst   <= ID_RegDst;
        EX_ALUOp    <= ID_ALUOp;
        EX_Valid    <= 1'b1;
      end
    end
  end

  // Debug counter saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use stall,
// $zero / UsesRt qualification, flush priority and counter saturation.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Flush;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
  logic        ID_UsesRt;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc;
  logic [1:0]  ID_RegDst;
  logic [3:0]  ID_ALUOp;

  logic [4:0]  EX_Rs, EX_Rt, EX_Rd, EX_Shamt;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc;
  logic [1:0]  EX_RegDst;
  logic [3:0]  EX_ALUOp;
  logic        EX_Valid, Stall;
  logic [15:0] StallCount;

  logic [4:0]  d2Rs, d2Rt, d2Rd, d2Shamt;
  logic [31:0] d2ReadData1, d2ReadData2, d2Imm, d2PC4;
  logic        d2RegWrite, d2MemRead, d2MemWrite, d2MemtoReg, d2ALUSrc;
  logic [1:0]  d2RegDst;
  logic [3:0]  d2ALUOp;
  logic        d2Valid, d2Stall;
  logic [1:0]  d2StallCount;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .Flush(Flush),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .ID_PC4(ID_PC4), .ID_Shamt(ID_Shamt), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg),
    .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_ALUOp(ID_ALUOp),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_ReadData1(EX_ReadData1),
    .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm), .EX_PC4(EX_PC4), .EX_Shamt(EX_Shamt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
    .EX_ALUOp(EX_ALUOp), .EX_Valid(EX_Valid), .Stall(Stall), .StallCount(StallCount)
  );

  id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dutSat (
    .clk(clk), .reset(reset), .Flush(Flush),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .ID_PC4(ID_PC4), .ID_Shamt(ID_Shamt), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg),
    .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_ALUOp(ID_ALUOp),
    .EX_Rs(d2Rs), .EX_Rt(d2Rt), .EX_Rd(d2Rd), .EX_ReadData1(d2ReadData1),
    .EX_ReadData2(d2ReadData2), .EX_Imm(d2Imm), .EX_PC4(d2PC4), .EX_Shamt(d2Shamt),
    .EX_RegWrite(d2RegWrite), .EX_MemRead(d2MemRead), .EX_MemWrite(d2MemWrite),
    .EX_MemtoReg(d2MemtoReg), .EX_ALUSrc(d2ALUSrc), .EX_RegDst(d2RegDst),
    .EX_ALUOp(d2ALUOp), .EX_Valid(d2Valid), .Stall(d2Stall), .StallCount(d2StallCount)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idIdle;
    ID_Rs = 0; ID_Rt = 0; ID_Rd = 0; ID_UsesRt = 0; ID_Shamt = 0;
    ID_ReadData1 = 0; ID_ReadData2 = 0; ID_Imm = 0; ID_PC4 = 0;
    ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0; ID_MemtoReg = 0;
    ID_ALUSrc = 0; ID_RegDst = REGDST_RT; ID_ALUOp = ALU_ADD;
  endtask

  task automatic idAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic usesRt);
    idIdle();
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRt = usesRt;
    ID_ReadData1 = 32'h1000 + 32'(rs); ID_ReadData2 = 32'h2000 + 32'(rt);
    ID_PC4 = 32'h0040_0004; ID_RegWrite = 1; ID_RegDst = REGDST_RD; ID_ALUOp = ALU_FUNCT;
  endtask

  task automatic idLw(input logic [4:0] rs, input logic [4:0] rt);
    idIdle();
    ID_Rs = rs; ID_Rt = rt; ID_Imm = 32'h0; ID_ReadData1 = 32'h1000 + 32'(rs);
    ID_RegWrite = 1; ID_MemRead = 1; ID_MemtoReg = 1; ID_ALUSrc = 1;
    ID_RegDst = REGDST_RT; ID_ALUOp = ALU_ADD;
  endtask

  initial begin
    reset = 1; Flush = 0;
    idIdle();
    tick(); tick();
    chk("rst_valid", 64'(EX_Valid), 64'd0);
    chk("rst_count", 64'(StallCount), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    reset = 0;

    // add $3,$1,$2 passes straight through in one cycle
    idAdd(5'd1, 5'd2, 5'd3, 1'b1);
    #1 chk("add_stall_pre", 64'(Stall), 64'd0);
    tick();
    chk("add_rs", 64'(EX_Rs), 64'd1);
    chk("add_rt", 64'(EX_Rt), 64'd2);
    chk("add_rd", 64'(EX_Rd), 64'd3);
    chk("add_regwrite", 64'(EX_RegWrite), 64'd1);
    chk("add_valid", 64'(EX_Valid), 64'd1);
    chk("add_rd1", 64'(EX_ReadData1), 64'h1001);
    chk("add_regdst", 64'(EX_RegDst), 64'(REGDST_RD));
    chk("add_stall_post", 64'(Stall), 64'd0);

    // lw $4,0($1) then add $5,$4,$6: exactly one stall cycle
    idLw(5'd1, 5'd4);
    tick();
    chk("lw_memread", 64'(EX_MemRead), 64'd1);
    idAdd(5'd4, 5'd6, 5'd5, 1'b1);
    #1 chk("lu_stall", 64'(Stall), 64'd1);
    tick();
    chk("lu_count", 64'(StallCount), 64'd1);
    chk("lu_bub_valid", 64'(EX_Valid), 64'd0);
    chk("lu_bub_regwrite", 64'(EX_RegWrite), 64'd0);
    chk("lu_bub_memread", 64'(EX_MemRead), 64'd0);
    chk("lu_bub_rs", 64'(EX_Rs), 64'd0);
    chk("lu_bub_rt", 64'(EX_Rt), 64'd0);
    chk("lu_stall_drop", 64'(Stall), 64'd0);
    tick();
    chk("lu_adv_rs", 64'(EX_Rs), 64'd4);
    chk("lu_adv_valid", 64'(EX_Valid), 64'd1);
    chk("lu_count_hold", 64'(StallCount), 64'd1);

    // reset mid-stall with lw $4,0($5) in EX: everything clears immediately
    idLw(5'd5, 5'd4);
    tick();
    idAdd(5'd4, 5'd6, 5'd5, 1'b1);
    #1 chk("mid_stall_pre", 64'(Stall), 64'd1);
    chk("mid_rs_pre", 64'(EX_Rs), 64'd5);
    #1 reset = 1;
    #1;
    chk("mid_rst_rs", 64'(EX_Rs), 64'd0);
    chk("mid_rst_regwrite", 64'(EX_RegWrite), 64'd0);
    chk("mid_rst_memread", 64'(EX_MemRead), 64'd0);
    chk("mid_rst_valid", 64'(EX_Valid), 64'd0);
    chk("mid_rst_rd1", 64'(EX_ReadData1), 64'd0);
    chk("mid_rst_count", 64'(StallCount), 64'd0);
    chk("mid_rst_stall", 64'(Stall), 64'd0);
    chk("mid_rst_count_sat", 64'(d2StallCount), 64'd0);
    #1 reset = 0;
    idIdle();
    tick();

    // load into $zero never stalls
    idLw(5'd1, 5'd0);
    tick();
    idAdd(5'd0, 5'd0, 5'd8, 1'b1);
    #1 chk("zero_stall", 64'(Stall), 64'd0);
    tick();
    chk("zero_count", 64'(StallCount), 64'd0);
    chk("zero_valid", 64'(EX_Valid), 64'd1);

    // rt match only counts when the instruction actually reads rt
    idLw(5'd2, 5'd7);
    tick();
    idAdd(5'd3, 5'd7, 5'd9, 1'b0);
    #1 chk("usesrt0_stall", 64'(Stall), 64'd0);
    ID_UsesRt = 1;
    #1 chk("usesrt1_stall", 64'(Stall), 64'd1);
    ID_UsesRt = 0;
    tick();
    chk("usesrt_count", 64'(StallCount), 64'd0);

    // flush beats a simultaneous load-use hazard
    idLw(5'd1, 5'd4);
    tick();
    idAdd(5'd4, 5'd6, 5'd5, 1'b1);
    Flush = 1;
    #1 chk("flush_stall", 64'(Stall), 64'd0);
    tick();
    Flush = 0;
    chk("flush_valid", 64'(EX_Valid), 64'd0);
    chk("flush_regwrite", 64'(EX_RegWrite), 64'd0);
    chk("flush_rd", 64'(EX_Rd), 64'd0);
    chk("flush_count", 64'(StallCount), 64'd0);

    // five load-use pairs: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      idLw(5'd1, 5'd4);
      tick();
      idAdd(5'd4, 5'd6, 5'd5, 1'b1);
      tick();
      chk($sformatf("sat_count2_%0d", i), 64'(d2StallCount), (i < 3) ? 64'(i + 1) : 64'd3);
      chk($sformatf("sat_count16_%0d", i), 64'(StallCount), 64'(i + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection built in.
- Captures decoded operands, register specifiers and control from ID, and presents them to EX.
- EX consumers are the ALU, the forwarding unit (via EX_Rs/EX_Rt) and the EX/MEM register.
- Inserts a bubble on a load-use hazard or on a branch/jump flush.
- Drives the stall signal to the PC and the IF/ID register, and keeps a saturating stall-cycle counter for debug.

Parameters:
- DATA_WIDTH, 32, width of the operand, immediate and PC+4 fields.
- CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Flush  input  1  wrong-path kill from branch/jump resolution; the ID instruction is discarded.
- ID_Rs  input  5  source register specifier rs.
- ID_Rt  input  5  source register specifier rt.
- ID_Rd  input  5  destination specifier rd.
- ID_UsesRt  input  1  instruction reads rt as a source (R-type, beq/bne, sw).
- ID_ReadData1  input  DATA_WIDTH  register file read port 1.
- ID_ReadData2  input  DATA_WIDTH  register file read port 2.
- ID_Imm  input  DATA_WIDTH  sign/zero-extended immediate.
- ID_PC4  input  DATA_WIDTH  PC+4 of the ID instruction.
- ID_Shamt  input  5  shift amount.
- ID_RegWrite  input  1  control bit for EX.
- ID_MemRead  input  1  control bit for EX.
- ID_MemWrite  input  1  control bit for EX.
- ID_MemtoReg  input  1  control bit for EX.
- ID_ALUSrc  input  1  control bit for EX.
- ID_RegDst  input  2  destination select: 00 rt, 01 rd, 10 r31.
- ID_ALUOp  input  4  ALU control encoding.
- EX_*  output  same widths as the ID_* inputs  registered copies: Rs, Rt, Rd, ReadData1, ReadData2, Imm, PC4, Shamt, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp.
- EX_Valid  output  1  EX holds a real instruction (0 = bubble).
- Stall  output  1  combinational; holds the PC and IF/ID this cycle.
- StallCount  output  CNT_WIDTH  number of load-use stall cycles since reset.

Behaviour:
- Reset, asynchronous, immediate:
  - all EX_* outputs, EX_Valid and StallCount go to 0;
  - Stall evaluates to 0 because EX_MemRead=0.
  - Reset mid-stall clears the in-flight load, so Stall drops in the same cycle.
- Hazard detection:
  - hazard = EX_MemRead & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & EX_Rt == ID_Rt)).
  - Stall = hazard & ~Flush & ~reset.
- Register update, one rising edge, priority order:
  - Flush=1: load a bubble.
  - else hazard=1: load a bubble.
  - else: load every ID_* field into its EX_* output, and set EX_Valid=1.
- Bubble: every control output, EX_Rs, EX_Rt, EX_Rd and EX_Valid = 0.
  - Data fields (ReadData1/2, Imm, PC4, Shamt) load from ID unchanged and are don't-care.
  - Zeroed specifiers guarantee the forwarding unit matches nothing.
- Latency: exactly 1 cycle from ID to EX. No enable input exists, so every cycle loads either a real instruction or a bubble.
- Load-use sequence: lw in EX plus a dependent instruction in ID gives exactly one stall cycle. On the next cycle EX holds the bubble, EX_MemRead=0, Stall=0, and the dependent instruction advances. Forwarding then supplies the value from MEM/WB.
- Flush and hazard in the same cycle: Flush wins, Stall=0, a bubble is inserted, StallCount is unchanged.
- StallCount: increments on each rising edge where Stall=1. It saturates at 2^CNT_WIDTH-1 and never wraps.
- A load to $zero (EX_Rt=0) never stalls.
- A back-to-back stall is impossible because the bubble clears EX_MemRead; no second stall cycle occurs.

Decomposition:
- Shared package mips_pkg:
  - RegDst encodings: REGDST_RT=2'b00, REGDST_RD=2'b01, REGDST_RA=2'b10.
  - ALUOp encodings.
  - Register-index width REG_W=5.
  - Zero register constant ZERO_REG=5'd0.
- One natural sub-module: hazard_detect_unit. It is combinational (hazard and Stall) and is instantiated inside id_ex_stage, so it can be verified standalone alongside the forwarding unit.
- The pipeline register and the counter stay in the top module.

Test Plan:
1. Reset asserted mid-operation with EX_RegWrite=1 and EX_Rs=5 → all EX_* outputs, EX_Valid and StallCount are 0 immediately, without waiting for a clock edge.
2. ID add $3,$1,$2 with no hazard → after 1 edge, EX_Rs=1, EX_Rt=2, EX_Rd=3, EX_RegWrite=1, EX_Valid=1, Stall=0 throughout.
3. lw $4,0($1) in EX, ID add $5,$4,$6 → Stall=1 for exactly one cycle and StallCount=1. Next edge: EX_Valid=0, EX_RegWrite=0, EX_Rs=EX_Rt=0. The following edge: the add reaches EX with EX_Rs=4.
4. lw $0 in EX with ID_Rs=0 → Stall=0 and StallCount is unchanged. lw $7 in EX with ID_Rt=7 and ID_UsesRt=0 → Stall=0.
5. Load-use hazard present together with Flush=1 → Stall=0, a bubble is inserted, StallCount is unchanged.
6. CNT_WIDTH=2, five consecutive load-use pairs → StallCount reads 1, 2, 3, 3, 3 (saturates, no wrap).
